pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB, 16 regs, 4-bit addrs).

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl_if.sv | 48 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and helpers for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DMEM_WAIT  = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALTED     = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } we_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic mem_wb;
    } flush_t;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    function automatic logic src_hit(input logic use_src,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return use_src && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs of the pipeline sequencer
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [pipeline_ctrl_pkg::REG_W-1:0] id_rs;
    logic [pipeline_ctrl_pkg::REG_W-1:0] id_rt;
    logic                                id_use_rs;
    logic                                id_use_rt;
    logic                                id_jr;
    logic                                id_hlt;
    logic [pipeline_ctrl_pkg::REG_W-1:0] ex_rd;
    logic                                ex_rw;
    logic                                ex_load;
    logic [pipeline_ctrl_pkg::REG_W-1:0] mem_rd;
    logic                                mem_rw;
    logic                                branch_taken;
    logic                                imem_rdy;
    logic                                dmem_req;
    logic                                dmem_rdy;
    logic                                pc_we;
    logic                                if_id_we;
    logic                                id_ex_we;
    logic                                ex_mem_we;
    logic                                mem_wb_we;
    logic                                if_id_flush;
    logic                                id_ex_flush;
    logic                                mem_wb_flush;
    logic                                halted;
    logic                                err;
    logic [CNT_W-1:0]                    stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_jr, id_hlt,
               ex_rd, ex_rw, ex_load, mem_rd, mem_rw,
               branch_taken, imem_rdy, dmem_req, dmem_rdy,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_flush, halted, err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_jr, id_hlt,
               ex_rd, ex_rw, ex_load, mem_rd, mem_rw,
               branch_taken, imem_rdy, dmem_req, dmem_rdy,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_flush, halted, err, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - load-use and JR-source hazards the forwarding network cannot cover
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jr,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rw,
    output logic             lu,
    output logic             jrh
);

    assign lu  = ex_load && (src_hit(id_use_rs, id_rs, ex_rd) || src_hit(id_use_rt, id_rt, ex_rd));

    // JR reads its target in ID; an EX ALU result is forwarded there, a load or MEM result is not.
    assign jrh = id_jr && (src_hit(ex_load, id_rs, ex_rd) || src_hit(mem_rw, id_rs, mem_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer owning every pipeline-register write enable
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC    = 3,
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  ctrl
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int TW = $clog2(DMEM_TIMEOUT + 1);

    ctrl_state_e    state_q, state_d;
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic           err_q, err_d;

    logic   lu, jrh, dmem_wait, run_rules;
    we_t    we;
    flush_t flush;

    pipeline_ctrl_hazard_detect u_hazard (
        .id_rs     (ctrl.id_rs),
        .id_rt     (ctrl.id_rt),
        .id_use_rs (ctrl.id_use_rs),
        .id_use_rt (ctrl.id_use_rt),
        .id_jr     (ctrl.id_jr),
        .ex_rd     (ctrl.ex_rd),
        .ex_load   (ctrl.ex_load),
        .mem_rd    (ctrl.mem_rd),
        .mem_rw    (ctrl.mem_rw),
        .lu        (lu),
        .jrh       (jrh)
    );

    assign dmem_wait = ctrl.dmem_req && !ctrl.dmem_rdy;

    always_comb begin
        we          = '1;
        flush       = '0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        to_cnt_d    = '0;
        err_d       = err_q;
        run_rules   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_wait) begin
                    we           = '0;
                    flush.mem_wb = 1'b1;
                    state_d      = ST_DMEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_DMEM_WAIT: begin
                if (dmem_wait) begin
                    we           = '0;
                    flush.mem_wb = 1'b1;
                    to_cnt_d     = (to_cnt_q == TW'(DMEM_TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
                    err_d        = err_q || (to_cnt_d == TW'(DMEM_TIMEOUT));
                end else begin
                    state_d   = ST_RUN;
                    run_rules = 1'b1;
                end
            end
            ST_HALT_DRAIN: begin
                if (dmem_wait) begin
                    we           = '0;
                    flush.mem_wb = 1'b1;
                end else begin
                    we.pc       = 1'b0;
                    flush.if_id = 1'b1;
                    if (drain_cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                we = '0;
            end
        endcase

        // A taken branch squashes whatever sits in IF/ID, so hazards and HLT there are wrong-path.
        if (run_rules) begin
            if (ctrl.branch_taken) begin
                flush.if_id = 1'b1;
                flush.id_ex = 1'b1;
            end else if (lu || jrh) begin
                we.pc       = 1'b0;
                we.if_id    = 1'b0;
                flush.id_ex = 1'b1;
            end else if (ctrl.id_hlt) begin
                we.pc       = 1'b0;
                flush.if_id = 1'b1;
                drain_cnt_d = DW'(DRAIN_CYC - 1);
                state_d     = ST_HALT_DRAIN;
            end else if (!ctrl.imem_rdy) begin
                we.pc       = 1'b0;
                flush.if_id = 1'b1;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!we.pc && (state_q != ST_HALTED) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    // Reset forces every stage register to load a bubble, independent of the clock.
    assign ctrl.pc_we        = rst_n && we.pc;
    assign ctrl.if_id_we     = rst_n && we.if_id;
    assign ctrl.id_ex_we     = rst_n && we.id_ex;
    assign ctrl.ex_mem_we    = rst_n && we.ex_mem;
    assign ctrl.mem_wb_we    = rst_n && we.mem_wb;
    assign ctrl.if_id_flush  = !rst_n || flush.if_id;
    assign ctrl.id_ex_flush  = !rst_n || flush.id_ex;
    assign ctrl.mem_wb_flush = !rst_n || flush.mem_wb;
    assign ctrl.halted       = (state_q == ST_HALTED);
    assign ctrl.err          = err_q;
    assign ctrl.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with directed hazard vectors
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .DRAIN_CYC    (3),
        .DMEM_TIMEOUT (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    typedef struct packed {
        logic [3:0] id_rs;
        logic [3:0] id_rt;
        logic       use_rs;
        logic       use_rt;
        logic       jr;
        logic       hlt;
        logic [3:0] ex_rd;
        logic       ex_rw;
        logic       ex_load;
        logic [3:0] mem_rd;
        logic       mem_rw;
        logic       br;
        logic       imem_rdy;
        logic       dreq;
        logic       drdy;
    } stim_t;

    typedef struct {
        string       name;
        logic [4:0]  we;
        logic [2:0]  fl;
        logic        halted;
        logic        err;
        logic [15:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    stim_t s;

    function automatic stim_t idle();
        stim_t r;
        r = '0;
        r.imem_rdy = 1'b1;
        return r;
    endfunction

    task automatic apply(input stim_t v);
        bus.id_rs        = v.id_rs;
        bus.id_rt        = v.id_rt;
        bus.id_use_rs    = v.use_rs;
        bus.id_use_rt    = v.use_rt;
        bus.id_jr        = v.jr;
        bus.id_hlt       = v.hlt;
        bus.ex_rd        = v.ex_rd;
        bus.ex_rw        = v.ex_rw;
        bus.ex_load      = v.ex_load;
        bus.mem_rd       = v.mem_rd;
        bus.mem_rw       = v.mem_rw;
        bus.branch_taken = v.br;
        bus.imem_rdy     = v.imem_rdy;
        bus.dmem_req     = v.dreq;
        bus.dmem_rdy     = v.drdy;
    endtask

    // we = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, mem_wb}
    task automatic cyc(input string name, input stim_t v, input logic [4:0] we,
                       input logic [2:0] fl, input logic h, input logic e, input int st);
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1;
        apply(v);
        x.name = name; x.we = we; x.fl = fl; x.halted = h; x.err = e; x.stall = 16'(st);
        sb_q.push_back(x);
    endtask

    task automatic reset_cyc(input string name);
        exp_t x;
        @(negedge clk);
        rst_n = 1'b0;
        apply(idle());
        x.name = name; x.we = 5'b00000; x.fl = 3'b111; x.halted = 1'b0; x.err = 1'b0; x.stall = '0;
        sb_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] a_we;
        logic [2:0] a_fl;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e    = sb_q.pop_front();
                a_we = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
                a_fl = {bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
                n_cmp++;
                if (a_we !== e.we || a_fl !== e.fl || bus.halted !== e.halted ||
                    bus.err !== e.err || bus.stall_cnt !== e.stall) begin
                    n_bad++;
                    $display("FAIL %s: got we=%b fl=%b halted=%b err=%b stall=%0d, expected we=%b fl=%b halted=%b err=%b stall=%0d",
                             e.name, a_we, a_fl, bus.halted, bus.err, bus.stall_cnt,
                             e.we, e.fl, e.halted, e.err, e.stall);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        apply(idle());

        // Load-use on rs and rt, and the register-0 / unused-source exclusions.
        reset_cyc("t1_reset");
        cyc("t1_idle", idle(), 5'b11111, 3'b000, 0, 0, 0);
        s = idle(); s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 5; s.id_rs = 5; s.use_rs = 1;
        cyc("t1_lu_rs", s, 5'b00111, 3'b010, 0, 0, 0);
        s.ex_load = 0;
        cyc("t1_lu_clear", s, 5'b11111, 3'b000, 0, 0, 1);
        s = idle(); s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 0; s.id_rs = 0; s.use_rs = 1;
        cyc("t1_lu_r0", s, 5'b11111, 3'b000, 0, 0, 1);
        s = idle(); s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 7; s.id_rt = 7; s.use_rt = 0;
        cyc("t1_lu_rt_unused", s, 5'b11111, 3'b000, 0, 0, 1);
        s.use_rt = 1;
        cyc("t1_lu_rt", s, 5'b00111, 3'b010, 0, 0, 1);
        cyc("t1_after", idle(), 5'b11111, 3'b000, 0, 0, 2);

        // JR behind a load stalls twice; JR on r0 or on an EX ALU result does not.
        reset_cyc("t2_reset");
        s = idle(); s.jr = 1; s.id_rs = 3; s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 3;
        cyc("t2_jr_ex_load", s, 5'b00111, 3'b010, 0, 0, 0);
        s = idle(); s.jr = 1; s.id_rs = 3; s.mem_rw = 1; s.mem_rd = 3;
        cyc("t2_jr_mem", s, 5'b00111, 3'b010, 0, 0, 1);
        cyc("t2_jr_done", idle(), 5'b11111, 3'b000, 0, 0, 2);
        s = idle(); s.jr = 1; s.id_rs = 0; s.mem_rw = 1; s.mem_rd = 0; s.ex_load = 1; s.ex_rd = 0;
        cyc("t2_jr_r0", s, 5'b11111, 3'b000, 0, 0, 2);
        s = idle(); s.jr = 1; s.id_rs = 4; s.ex_rw = 1; s.ex_rd = 4;
        cyc("t2_jr_ex_alu", s, 5'b11111, 3'b000, 0, 0, 2);

        // Taken branch wins over load-use and HLT.
        reset_cyc("t3_reset");
        s = idle(); s.br = 1; s.hlt = 1; s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 5; s.id_rs = 5; s.use_rs = 1;
        cyc("t3_branch", s, 5'b11111, 3'b110, 0, 0, 0);
        cyc("t3_still_run", idle(), 5'b11111, 3'b000, 0, 0, 0);

        // D-mem waits: 3 cycles stays below the timeout, 4 cycles trips it.
        reset_cyc("t4_reset");
        s = idle(); s.dreq = 1; s.drdy = 0;
        for (int i = 0; i < 3; i++) cyc("t4_wait3", s, 5'b00000, 3'b001, 0, 0, i);
        s.drdy = 1;
        cyc("t4_release3", s, 5'b11111, 3'b000, 0, 0, 3);
        cyc("t4_idle3", idle(), 5'b11111, 3'b000, 0, 0, 3);
        s = idle(); s.dreq = 1; s.drdy = 0;
        for (int i = 0; i < 4; i++) cyc("t4_wait4", s, 5'b00000, 3'b001, 0, 0, 3 + i);
        s.drdy = 1; s.br = 1;
        cyc("t4_release_branch", s, 5'b11111, 3'b110, 0, 1, 7);
        cyc("t4_err_sticky", idle(), 5'b11111, 3'b000, 0, 1, 7);

        // HLT drain: plain, stretched by a D-mem wait, and cut short by reset.
        reset_cyc("t5_reset");
        s = idle(); s.hlt = 1;
        cyc("t5_hlt", s, 5'b01111, 3'b100, 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc("t5_drain", idle(), 5'b01111, 3'b100, 0, 0, i);
        cyc("t5_halted", idle(), 5'b00000, 3'b000, 1, 0, 4);
        cyc("t5_halted_hold", idle(), 5'b00000, 3'b000, 1, 0, 4);

        reset_cyc("t5b_reset");
        s = idle(); s.hlt = 1;
        cyc("t5b_hlt", s, 5'b01111, 3'b100, 0, 0, 0);
        s = idle(); s.dreq = 1; s.drdy = 0;
        cyc("t5b_drain_wait", s, 5'b00000, 3'b001, 0, 0, 1);
        for (int i = 2; i <= 4; i++) cyc("t5b_drain", idle(), 5'b01111, 3'b100, 0, 0, i);
        cyc("t5b_halted", idle(), 5'b00000, 3'b000, 1, 0, 5);

        reset_cyc("t5c_reset");
        s = idle(); s.hlt = 1;
        cyc("t5c_hlt", s, 5'b01111, 3'b100, 0, 0, 0);
        cyc("t5c_drain", idle(), 5'b01111, 3'b100, 0, 0, 1);
        reset_cyc("t5c_mid_reset");
        cyc("t5c_run_again", idle(), 5'b11111, 3'b000, 0, 0, 0);
        cyc("t5c_no_halt", idle(), 5'b11111, 3'b000, 0, 0, 0);

        // Fetch wait bubbles.
        reset_cyc("t6_reset");
        s = idle(); s.imem_rdy = 0;
        cyc("t6_imem_wait", s, 5'b01111, 3'b100, 0, 0, 0);
        cyc("t6_imem_wait", s, 5'b01111, 3'b100, 0, 0, 1);
        cyc("t6_resume", idle(), 5'b11111, 3'b000, 0, 0, 2);

        @(negedge clk);
        apply(idle());
        #4;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
